// File: rtl/univ_shift_counter_if.sv
// univ_shift_counter_if: control, data and status bundle of the
// universal counter/shift register; master drives, slave is the register.
interface univ_shift_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             SCLR;
  logic [2:0]       MODE;
  logic             ENP;
  logic             ENT;
  logic [WIDTH-1:0] D;
  logic             SL_IN;
  logic             SR_IN;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             SO;
  logic             WRAP;

  modport master (
    output SCLR, MODE, ENP, ENT, D,
    output SL_IN, SR_IN,
    input  Q, RCO, SO, WRAP
  );

  modport slave (
    input  SCLR, MODE, ENP, ENT, D,
    input  SL_IN, SR_IN,
    output Q, RCO, SO, WRAP
  );
endinterface

// File: rtl/univ_shift_counter.sv
// univ_shift_counter: up/down modulo-N counter, parallel-load register
// and shift/rotate register in one block, cascadable through ENT/RCO.
module univ_shift_counter #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  parameter int unsigned     RST_VAL = 0
) (
  input logic                CLK,
  input logic                CLR_n,
  univ_shift_counter_if.slave bus
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_UP   = 3'b001;
  localparam logic [2:0] M_DOWN = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_SHL  = 3'b100;
  localparam logic [2:0] M_SHR  = 3'b101;
  localparam logic [2:0] M_ROL  = 3'b110;
  localparam logic [2:0] M_ROR  = 3'b111;

  localparam logic [WIDTH-1:0] MAXV =
    WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RSTV =
    WIDTH'(RST_VAL);

  if (WIDTH < 2 || WIDTH > 32 ||
      MODULUS < 2 ||
      MODULUS > (64'd1 << WIDTH) ||
      64'(RST_VAL) >= MODULUS) begin : g_bad_param
    $error("univ_shift_counter: illegal WIDTH/MODULUS/RST_VAL");
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_so;
  logic             w_so_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             w_top;
  logic             w_bot;
  logic             w_cnt_en;

  // Loaded values above MODULUS-1 count as "at top" so UP still wraps.
  assign w_top    = (r_q >= MAXV);
  assign w_bot    = (r_q == '0);
  assign w_cnt_en = bus.ENP & bus.ENT;

  always_comb begin
    w_q_nxt    = r_q;
    w_so_nxt   = r_so;
    w_wrap_nxt = 1'b0;
    unique case (bus.MODE)
      M_HOLD: begin
      end
      M_UP: begin
        if (w_cnt_en) begin
          w_q_nxt    = w_top ? '0 : r_q + WIDTH'(1);
          w_wrap_nxt = w_top;
        end
      end
      M_DOWN: begin
        if (w_cnt_en) begin
          w_q_nxt    = w_bot ? MAXV : r_q - WIDTH'(1);
          w_wrap_nxt = w_bot;
        end
      end
      M_LOAD: begin
        w_q_nxt = bus.D;
      end
      M_SHL: begin
        w_q_nxt  = {r_q[WIDTH-2:0], bus.SL_IN};
        w_so_nxt = r_q[WIDTH-1];
      end
      M_SHR: begin
        w_q_nxt  = {bus.SR_IN, r_q[WIDTH-1:1]};
        w_so_nxt = r_q[0];
      end
      M_ROL: begin
        w_q_nxt  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_so_nxt = r_q[WIDTH-1];
      end
      M_ROR: begin
        w_q_nxt  = {r_q[0], r_q[WIDTH-1:1]};
        w_so_nxt = r_q[0];
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_q    <= RSTV;
      r_so   <= 1'b0;
      r_wrap <= 1'b0;
    end else if (bus.SCLR) begin
      r_q    <= RSTV;
      r_so   <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_so   <= w_so_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  // RCO ignores ENP so a cascade can look ahead while paused.
  assign bus.RCO = bus.ENT &
    (((bus.MODE == M_UP) & w_top) |
     ((bus.MODE == M_DOWN) & w_bot));

  assign bus.Q    = r_q;
  assign bus.SO   = r_so;
  assign bus.WRAP = r_wrap;

endmodule
